// File: rtl/sig_accumulator_if.sv
// Sample handshake between the upstream test module's `y` bus and the signature stage.
// The upstream side is the master; the accumulator consumes through the slave modport.
interface sig_accumulator_if #(
   parameter int DATA_W = 1459
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/sig_accumulator.sv
// Folds NUM_SAMPLES wide samples into one SIG_W-bit signature, one chunk per clock.
// Optional build macro SIG_ACC_MIX_INDEX_EN also mixes the chunk index into every fold.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | in_ready high, waiting for the next sample
// FOLD  | folding the held sample, one SIG_W chunk per cycle
// DONE  | final signature presented (sig_valid), waiting for start
module sig_accumulator #(
   parameter int               DATA_W      = 1459,
   parameter int               SIG_W       = 32,
   parameter int               NUM_SAMPLES = 256,
   parameter logic [SIG_W-1:0] SEED        = '0,
   localparam int              CHUNKS      = (DATA_W + SIG_W - 1) / SIG_W,
   localparam int              CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   sig_accumulator_if.slave     in_if,
   output logic [SIG_W-1:0]     sig,
   output logic                 sig_valid,
   output logic                 busy,
   output logic [CNT_W-1:0]     sample_cnt
);

   localparam int HOLD_W = CHUNKS * SIG_W;
   localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CHUNKS - 1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(NUM_SAMPLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_FOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SIG_W-1:0]  sig_q, sig_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SIG_W-1:0]  chunk;
   logic [SIG_W-1:0]  folded;

   // The hold register is padded to whole chunks and shifted down one chunk per
   // fold, so the current chunk is always the bottom slice and padding reads as 0.
   assign chunk = hold_q[SIG_W-1:0];

`ifdef SIG_ACC_MIX_INDEX_EN
   assign folded = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ chunk ^ SIG_W'(idx_q);
`else
   assign folded = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ chunk;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sig_d   = SEED;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (in_if.in_valid) begin
               hold_d  = HOLD_W'(in_if.in_data);
               idx_d   = '0;
               state_d = ST_FOLD;
            end
         end
         ST_FOLD: begin
            sig_d  = folded;
            hold_d = hold_q >> SIG_W;
            if (idx_q == IDX_LAST) begin
               cnt_d   = cnt_q + 1'b1;
               idx_d   = '0;
               state_d = (cnt_d == CNT_TARGET) ? ST_DONE : ST_WAIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
         sig_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
      end
   end

   // in_ready depends on the state register alone; in_valid never reaches it.
   assign in_if.in_ready = (state_q == ST_WAIT);
   assign busy           = (state_q == ST_WAIT) || (state_q == ST_FOLD);
   assign sig_valid      = (state_q == ST_DONE);
   assign sig            = sig_q;
   assign sample_cnt     = cnt_q;

endmodule

// File: tb/tb_sig_accumulator.sv
// Bench for sig_accumulator: three instances with different sample counts and seeds,
// driven with directed and random samples and checked against a chunk-fold model.
module tb_sig_accumulator;

   localparam int DW = 1459;
   localparam int SW = 32;
   localparam int CH = (DW + SW - 1) / SW;

   logic clk;
   logic rst_n;
   logic          start_r [3];
   logic          valid_r [3];
   logic [DW-1:0] data_r  [3];
   logic          ready_w [3];
   logic [SW-1:0] sig_w   [3];
   logic          sv_w    [3];
   logic          busy_w  [3];
   logic [7:0]    cnt_w   [3];

   int n_checks = 0;
   int n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int          NSG = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
      localparam logic [31:0] SDG = (g == 0) ? 32'h0 : ((g == 1) ? 32'hFFFF_FFFF : 32'hA5C3_0F1E);
      localparam int          CWG = $clog2(NSG + 1);
      logic [CWG-1:0] cnt;

      sig_accumulator_if #(.DATA_W(DW)) u_if ();
      assign u_if.in_valid = valid_r[g];
      assign u_if.in_data  = data_r[g];
      assign ready_w[g]    = u_if.in_ready;
      assign cnt_w[g]      = 8'(cnt);

      sig_accumulator #(
         .DATA_W(DW), .SIG_W(SW), .NUM_SAMPLES(NSG), .SEED(SDG)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .start(start_r[g]),
         .in_if(u_if),
         .sig(sig_w[g]),
         .sig_valid(sv_w[g]),
         .busy(busy_w[g]),
         .sample_cnt(cnt)
      );
   end

   function automatic int ns_of(int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
   endfunction

   function automatic logic [31:0] seed_of(int k);
      return (k == 0) ? 32'h0 : ((k == 1) ? 32'hFFFF_FFFF : 32'hA5C3_0F1E);
   endfunction

   // Reference: the sample split into 32-bit words from the LSB, zero-padded, each
   // word XORed into the signature after a 1-bit left rotate.
   function automatic logic [31:0] fold(logic [31:0] s, logic [DW-1:0] d);
      logic [31:0] w;
      for (int c = 0; c < CH; c++) begin
         w = '0;
         for (int b = 0; b < 32; b++)
            if (c * 32 + b < DW) w[b] = d[c * 32 + b];
         s = (s << 1) | (s >> 31);
         s = s ^ w;
`ifdef SIG_ACC_MIX_INDEX_EN
         s = s ^ 32'(c);
`endif
      end
      return s;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      logic [31:0]   w;
      w = '0;
      for (int i = 0; i < DW; i++) begin
         if (i % 32 == 0) w = $urandom;
         r[i] = w[i % 32];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] make_data(int mode);
      logic [DW-1:0] d;
      d = '0;
      if (mode == 1) d = rnd_data();
      else if (mode == 2) d[0] = 1'b1;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_zero(int k, string tag);
      chk({tag, "_sig"},   64'(sig_w[k]),   64'h0);
      chk({tag, "_valid"}, 64'(sv_w[k]),    64'h0);
      chk({tag, "_busy"},  64'(busy_w[k]),  64'h0);
      chk({tag, "_ready"}, 64'(ready_w[k]), 64'h0);
      chk({tag, "_cnt"},   64'(cnt_w[k]),   64'h0);
   endtask

   task automatic do_start(int k, string tag);
      start_r[k] = 1'b1;
      tick();
      start_r[k] = 1'b0;
      chk({tag, "_start_sig"},   64'(sig_w[k]),   64'(seed_of(k)));
      chk({tag, "_start_cnt"},   64'(cnt_w[k]),   64'h0);
      chk({tag, "_start_valid"}, 64'(sv_w[k]),    64'h0);
      chk({tag, "_start_ready"}, 64'(ready_w[k]), 64'h1);
   endtask

   // Waits (bounded) for in_ready, transfers d, optionally disturbs start/in_valid
   // for 40 fold cycles. used = cycles consumed after the accepting edge.
   task automatic send(int k, logic [DW-1:0] d, bit perturb, string tag, output int used);
      int i;
      used = 0;
      i = 0;
      while (!ready_w[k] && i < 100) begin
         tick();
         i++;
      end
      chk({tag, "_ready_seen"}, 64'(ready_w[k]), 64'h1);
      chk({tag, "_no_early_valid"}, 64'(sv_w[k]), 64'h0);
      valid_r[k] = 1'b1;
      data_r[k]  = d;
      tick();
      valid_r[k] = 1'b0;
      chk({tag, "_fold_ready_low"}, 64'(ready_w[k]), 64'h0);
      if (perturb) begin
         for (int j = 0; j < 40; j++) begin
            start_r[k] = (j % 3 == 0);
            valid_r[k] = (j % 2 == 1);
            data_r[k]  = rnd_data();
            tick();
            used++;
         end
         start_r[k] = 1'b0;
         valid_r[k] = 1'b0;
      end
   endtask

   task automatic run(int k, int mode, bit perturb, string tag);
      logic [31:0] exp;
      logic [DW-1:0] d;
      int used;
      int n;
      exp = seed_of(k);
      do_start(k, tag);
      for (int s = 0; s < ns_of(k); s++) begin
         d   = make_data(mode);
         exp = fold(exp, d);
         send(k, d, perturb, tag, used);
      end
      n = used;
      while (!sv_w[k] && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_done_latency"}, 64'(n), 64'(CH));
      chk({tag, "_sig"},  64'(sig_w[k]),  64'(exp));
      chk({tag, "_cnt"},  64'(cnt_w[k]),  64'(ns_of(k)));
      chk({tag, "_busy"}, 64'(busy_w[k]), 64'h0);
      repeat (3) tick();
      chk({tag, "_sig_hold"},   64'(sig_w[k]),   64'(exp));
      chk({tag, "_valid_hold"}, 64'(sv_w[k]),    64'h1);
      chk({tag, "_ready_done"}, 64'(ready_w[k]), 64'h0);
   endtask

   initial begin
      logic [31:0]   exp;
      logic [DW-1:0] d;
      int            used;
      int            xfers;
      int            xc [3];
      bit            done;

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_r[k] = 1'b0;
         valid_r[k] = 1'b0;
         data_r[k]  = '0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset%0d", k));
      rst_n = 1'b1;
      tick();

      // Single bit-0 sample from seed 0: one XOR then 45 rotations.
      run(0, 2, 1'b0, "bit0");
`ifndef SIG_ACC_MIX_INDEX_EN
      chk("bit0_const", 64'(sig_w[0]), 64'h0000_2000);
`endif

      run(1, 0, 1'b0, "zeros4");
`ifndef SIG_ACC_MIX_INDEX_EN
      chk("zeros4_const", 64'(sig_w[1]), 64'hFFFF_FFFF);
`endif
      run(1, 1, 1'b0, "rand4");
      run(0, 1, 1'b0, "rand1");

      // in_valid held high across a 3-sample run.
      exp = seed_of(2);
      valid_r[2] = 1'b1;
      do_start(2, "stream");
      xfers = 0;
      done  = 1'b0;
      for (int c = 0; c < 3 * (CH + 1) + 20 && !done; c++) begin
         data_r[2] = rnd_data();
         if (sv_w[2]) done = 1'b1;
         else begin
            if (ready_w[2]) begin
               if (xfers < 3) xc[xfers] = c;
               xfers++;
               exp = fold(exp, data_r[2]);
            end
            tick();
         end
      end
      chk("stream_done_seen", 64'(done), 64'h1);
      chk("stream_xfers", 64'(xfers), 64'h3);
      chk("stream_gap01", 64'(xc[1] - xc[0]), 64'(CH + 1));
      chk("stream_gap12", 64'(xc[2] - xc[1]), 64'(CH + 1));
      chk("stream_sig", 64'(sig_w[2]), 64'(exp));
      chk("stream_busy_done", 64'(busy_w[2]), 64'h0);
      chk("stream_ready_done", 64'(ready_w[2]), 64'h0);
      valid_r[2] = 1'b0;
      tick();

      // start pulses and in_valid toggling while folding must not disturb the run.
      run(2, 1, 1'b1, "perturb");
      do_start(2, "restart");
      chk("restart_busy", 64'(busy_w[2]), 64'h1);
      run(2, 1, 1'b0, "rand3");

      // Reset at idx=20 of a fold, then a clean bit-0 run.
      do_start(0, "rstmid");
      d = rnd_data();
      send(0, d, 1'b0, "rstmid", used);
      repeat (20) tick();
      chk("rstmid_busy", 64'(busy_w[0]), 64'h1);
      rst_n = 1'b0;
      start_r[0] = 1'b1;
      valid_r[0] = 1'b1;
      tick();
      rst_n = 1'b1;
      start_r[0] = 1'b0;
      valid_r[0] = 1'b0;
      chk_zero(0, "rstmid_after");
      run(0, 2, 1'b0, "post_rst");
`ifndef SIG_ACC_MIX_INDEX_EN
      chk("post_rst_const", 64'(sig_w[0]), 64'h0000_2000);
`endif

      // All-zero data from seed 0: any nonzero result comes only from index mixing.
      run(0, 0, 1'b0, "zeros1");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
